instr_fetch: RTL and testbench

Instruction-fetch stage of the single-cycle RISC-V core, directly upstream of the controller. Holds the PC, issues requests to instruction memory over a ready handshake, and presents a stable `instr` word to the controller and datapath until it is retired. On retire it selects the next PC from `pc_src1`/`pc_src0` (sequential, branch/jal target, or jalr target) and starts the next fetch.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/next_pc_calc.sv | 34 +++
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the single-cycle RISC-V core front end.
// Optional: INSTR_FETCH_MISALIGN_TRAP_EN adds the FAULT fetch state.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_TARGET = 2'b01,
    PC_JALR   = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    ,
    FAULT = 2'b10
`endif
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC adders, jalr mask, select mux and misalign detect.
// Select code 11 is reserved and falls back to sequential.
module next_pc_calc
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] pc_target;
  logic [31:0] jalr_target;

  assign pc_plus4    = pc + 32'd4;
  assign pc_target   = pc + imm_ext;
  assign jalr_target = alu_result & ~32'h1;

  // Pick the retire target; anything unrecognised is sequential.
  always_comb begin
    next_pc = pc_plus4;
    unique case (1'b1)
      (pc_sel == PC_TARGET): next_pc = pc_target;
      (pc_sel == PC_JALR):   next_pc = jalr_target;
      default:               next_pc = pc_plus4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds PC, fetches over a ready handshake, holds instr.
// Optional: INSTR_FETCH_MISALIGN_TRAP_EN traps misaligned targets.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_src0,
  input  logic        pc_src1,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  input  logic        instr_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [31:0] next_pc;
  logic [31:0] pc_retire;
  logic        misaligned;
  logic        retire;

  next_pc_calc u_next_pc (
    .pc         (pc_q),
    .pc_sel     ({pc_src1, pc_src0}),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  assign retire = (state_q == HOLD) && instr_ack;

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  assign pc_retire   = next_pc;
  assign fetch_fault = fault_q;
`else
  assign pc_retire   = misaligned ? {next_pc[31:2], 2'b00} : next_pc;
  assign fetch_fault = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next state and memory request.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = HOLD;
      end
      HOLD: begin
        if (instr_ack) begin
          state_d = FETCH;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
          if (misaligned) state_d = FAULT;
`endif
        end
      end
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = FETCH;
    endcase
  end

  // Capture fetched word; advance PC on retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      if (state_q == FETCH && imem_ready) begin
        instr_q <= imem_rdata;
        valid_q <= 1'b1;
      end
      if (retire) begin
        pc_q    <= pc_retire;
        valid_q <= 1'b0;
      end
    end
  end

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  // Sticky fault flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)                      fault_q <= 1'b0;
    else if (retire && misaligned) fault_q <= 1'b1;
  end
`endif

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch.
// Build with INSTR_FETCH_MISALIGN_TRAP_EN to exercise the trap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src0, pc_src1;
  logic [31:0] imm_ext, alu_result;
  logic        instr_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory returns a word tagged with its address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  assign imem_rdata = word_at(imem_addr);

  instr_fetch #(.RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_src0     (pc_src0),
    .pc_src1     (pc_src1),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .instr_ack   (instr_ack),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_fault (fetch_fault)
  );

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // From FETCH: complete one fetch, retire with sel, land in FETCH.
  task automatic fetch_retire(input logic [1:0] sel,
                              input logic [31:0] imm,
                              input logic [31:0] alu);
    imem_ready = 1'b1;
    instr_ack  = 1'b0;
    step();
    imem_ready = 1'b0;
    instr_ack  = 1'b1;
    {pc_src1, pc_src0} = sel;
    imm_ext    = imm;
    alu_result = alu;
    step();
    instr_ack = 1'b0;
    {pc_src1, pc_src0} = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc got %h want %h", pc, 32'h0);
    end
    n_checks++;
    if (instr !== 32'h13) begin
      n_fail++; $display("FAIL reset_instr got %h want %h", instr, 32'h13);
    end
    n_checks++;
    if (instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got v=%b f=%b want 0 0", instr_valid, fetch_fault);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_plus4 !== 32'h4) begin
      n_fail++;
      $display("FAIL first_req got req=%b addr=%h p4=%h want 1 0 4",
               imem_req, imem_addr, pc_plus4);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] a;
    imem_ready = 1'b1;
    instr_ack  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = 32'(4 * (k / 2));
      if (k % 2 == 0) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL seq_fetch k=%0d got req=%b addr=%h v=%b want 1 %h 0",
                   k, imem_req, imem_addr, instr_valid, a);
        end
      end else begin
        n_checks++;
        if (imem_req !== 1'b0 || pc !== a || instr_valid !== 1'b1 ||
            instr !== word_at(a)) begin
          n_fail++;
          $display("FAIL seq_hold k=%0d got req=%b pc=%h v=%b i=%h want 0 %h 1 %h",
                   k, imem_req, pc, instr_valid, instr, a, word_at(a));
        end
      end
      step();
    end
    imem_ready = 1'b0;
    instr_ack  = 1'b0;
    n_checks++;
    if (imem_addr !== 32'hC) begin
      n_fail++; $display("FAIL seq_end got %h want %h", imem_addr, 32'hC);
    end
  endtask

  task automatic test_wait_states;
    fetch_retire(2'b00, 32'h0, 32'h0);
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (imem_addr !== 32'h10 || imem_req !== 1'b1 ||
          instr !== word_at(32'hC) || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_hold k=%0d got addr=%h req=%b i=%h v=%b want 10 1 %h 0",
                 k, imem_addr, imem_req, instr, instr_valid, word_at(32'hC));
      end
      if (k == 3) imem_ready = 1'b1;
      step();
    end
    imem_ready = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== word_at(32'h10)) begin
      n_fail++;
      $display("FAIL wait_capture got v=%b i=%h want 1 %h",
               instr_valid, instr, word_at(32'h10));
    end
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
  endtask

  task automatic test_branch;
    for (int k = 0; k < 3; k++) fetch_retire(2'b00, 32'h0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h20) begin
      n_fail++; $display("FAIL br_setup got %h want %h", imem_addr, 32'h20);
    end
    fetch_retire(2'b01, 32'hFFFF_FFF0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h10) begin
      n_fail++; $display("FAIL br_target got %h want %h", imem_addr, 32'h10);
    end
    fetch_retire(2'b10, 32'h0, 32'h105);
    n_checks++;
    if (imem_addr !== 32'h104) begin
      n_fail++; $display("FAIL br_jalr got %h want %h", imem_addr, 32'h104);
    end
    fetch_retire(2'b11, 32'h40, 32'h80);
    n_checks++;
    if (imem_addr !== 32'h108) begin
      n_fail++; $display("FAIL br_resv got %h want %h", imem_addr, 32'h108);
    end
  endtask

  task automatic test_ack_in_fetch;
    instr_ack  = 1'b1;
    imem_ready = 1'b0;
    step();
    step();
    step();
    n_checks++;
    if (pc !== 32'h108 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_fetch got pc=%h req=%b want 108 1", pc, imem_req);
    end
    instr_ack = 1'b0;
    fetch_retire(2'b10, 32'h0, 32'hFFFF_FFFD);
    n_checks++;
    if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_setup got pc=%h p4=%h want fffffffc 0", pc, pc_plus4);
    end
    fetch_retire(2'b00, 32'h0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap got %h want %h", imem_addr, 32'h0);
    end
  endtask

  task automatic test_reset_mid;
    fetch_retire(2'b10, 32'h0, 32'h40);
    imem_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_ready = 1'b0;
    n_checks++;
    if (instr !== 32'h13 || instr_valid !== 1'b0 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_req got i=%h v=%b pc=%h want 13 0 0", instr, instr_valid, pc);
    end
    step();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_refetch got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    fetch_retire(2'b00, 32'h0, 32'h0);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h13) begin
      n_fail++;
      $display("FAIL rst_hold got v=%b pc=%h i=%h want 0 0 13", instr_valid, pc, instr);
    end
    step();
  endtask

  task automatic test_misalign;
    fetch_retire(2'b00, 32'h0, 32'h0);
    fetch_retire(2'b00, 32'h0, 32'h0);
    fetch_retire(2'b01, 32'h2, 32'h0);
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    imem_ready = 1'b1;
    instr_ack  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (fetch_fault !== 1'b1 || pc !== 32'hA || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL trap k=%0d got f=%b pc=%h req=%b want 1 a 0",
                 k, fetch_fault, pc, imem_req);
      end
      step();
    end
    imem_ready = 1'b0;
    instr_ack  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL trap_exit got f=%b req=%b pc=%h want 0 1 0",
               fetch_fault, imem_req, pc);
    end
`else
    n_checks++;
    if (fetch_fault !== 1'b0 || pc !== 32'h8 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL align_force got f=%b pc=%h req=%b want 0 8 1",
               fetch_fault, pc, imem_req);
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    pc_src0    = 1'b0;
    pc_src1    = 1'b0;
    imm_ext    = 32'h0;
    alu_result = 32'h0;
    instr_ack  = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch();
    test_ack_in_fetch();
    test_reset_mid();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
